fetch_pc_unit: RTL

Instruction fetch stage that sits directly upstream of the opcode decoder. Holds the PC and fetches instructions from instruction memory over a req/ready handshake. Presents the fetched word and its opcode field to the decoder. Consumes the decoder's Jump/Branch/BranchNe outputs, the ALU zero flag and the jr request to select the next PC.

---
 rtl/fetch_pc_unit_if.sv | 22 ++
 rtl/fetch_pc_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request bus used by fetch_pc_unit.
// master issues req/addr; slave answers with rdata/ready.
interface fetch_pc_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, imem req/ready fetch and next-PC select.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   fetch_pc_unit_if.master imem,
   input  logic            Jump,
   input  logic            Branch,
   input  logic            BranchNe,
   input  logic            zero,
   input  logic            jr_en,
   input  logic [31:0]     rs_data,
   output logic [31:0]     pc,
   output logic [31:0]     pc_plus4,
   output logic [31:0]     instr,
   output logic [5:0]      opcode,
   output logic            instr_valid,
   output logic            fetch_err
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc;
   logic [31:0] br_off;
   logic [31:0] seq_pc;
   logic        take_br;
   logic        timeout_hit;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("fetch_pc_unit: TIMEOUT must be 2..255");
   end

   assign seq_pc  = pc_q + 32'd4;
   assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign take_br = (Branch & zero) | (BranchNe & ~zero);

   // if/else chain keeps Branch/BranchNe out of the jump path entirely
   always_comb begin
      next_pc = seq_pc;
      if (jr_en) begin
         next_pc = rs_data & 32'hFFFF_FFFC;
      end else if (Jump) begin
         next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
      end else if (take_br) begin
         next_pc = seq_pc + br_off;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;

   assign timeout_hit = (state_q == REQ)
                      && !imem.imem_ready
                      && (wait_q == 8'(TIMEOUT - 1));

   // counter sits at zero outside REQ, so every REQ entry starts fresh
   always_comb begin
      wait_d = wait_q;
      err_d  = err_q;
      if (state_q != REQ) begin
         wait_d = 8'd0;
      end else if (!imem.imem_ready) begin
         wait_d = wait_q + 8'd1;
      end
      if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         BOOT: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = VALID;
            end else if (timeout_hit) begin
               instr_d = 32'h0000_0000;
               state_d = VALID;
            end
         end
         VALID: begin
            if (!stall) begin
               pc_d    = next_pc;
               state_d = REQ;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_comb begin
      imem.imem_req  = (state_q == REQ);
      imem.imem_addr = pc_q;
      instr_valid    = (state_q == VALID);
      pc             = pc_q;
      pc_plus4       = seq_pc;
      instr          = instr_q;
      opcode         = instr_q[31:26];
   end

endmodule
